// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the downstream consumer.
// Combinational grants; out1/out_valid/sel are driven by the arbiter side.
// master = requester/consumer side, slave = arbiter side.
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 3
);
  logic             req1;
  logic [WIDTH-1:0] in1;
  logic             gnt1;
  logic             req2;
  logic [WIDTH-1:0] in2;
  logic             gnt2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out1;
  logic             sel;

  modport master (
    output req1, in1, req2, in2, out_ready,
    input  gnt1, gnt2, out_valid, out1, sel
  );

  modport slave (
    input  req1, in1, req2, in2, out_ready,
    output gnt1, gnt2, out_valid, out1, sel
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin two-way mux arbiter with bounded hold; drives sel and one registered output beat.
// Latency: a beat granted in cycle N is on out1 with out_valid=1 in cycle N+1.
// Backpressure: grants are withheld and all state frozen while out_valid && !out_ready.
module rr_mux_arbiter #(
  parameter int WIDTH    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_mux_arbiter_if.slave    bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PICK_NONE = 2'd0,
    PICK_1    = 2'd1,
    PICK_2    = 2'd2
  } pick_e;

  state_e           state_q, state_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             prio1_q, prio1_d;       // 1: in1 wins a tie from IDLE
  logic             last_sel_q, last_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out1_q, out1_d;

  pick_e            pick;
  logic             can_accept;
  logic             gnt1_o, gnt2_o, sel_o;

  // State register: reset wins over any grant, so an in-flight beat is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      prio1_q     <= 1'b1;
      last_sel_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out1_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      prio1_q     <= prio1_d;
      last_sel_q  <= last_sel_d;
      out_valid_q <= out_valid_d;
      out1_q      <= out1_d;
    end
  end

  // Pick the next owner and compute next state; the hold limit only bites when the other side requests.
  always_comb begin
    can_accept = !out_valid_q || bus.out_ready;
    pick       = PICK_NONE;

    if (rst_n && can_accept) begin
      case (state_q)
        OWN1: begin
          if (bus.req1 && (hold_cnt_q < HOLD_MAX || !bus.req2)) pick = PICK_1;
          else if (bus.req2)                                     pick = PICK_2;
        end
        OWN2: begin
          if (bus.req2 && (hold_cnt_q < HOLD_MAX || !bus.req1)) pick = PICK_2;
          else if (bus.req1)                                     pick = PICK_1;
        end
        default: begin
          if (bus.req1 && bus.req2) pick = prio1_q ? PICK_1 : PICK_2;
          else if (bus.req1)        pick = PICK_1;
          else if (bus.req2)        pick = PICK_2;
        end
      endcase
    end

    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    prio1_d     = prio1_q;
    last_sel_d  = last_sel_q;
    out_valid_d = out_valid_q;
    out1_d      = out1_q;

    if (pick != PICK_NONE) begin
      // A grant always loads the output stage; the old beat (if any) leaves on the same edge.
      state_d = (pick == PICK_1) ? OWN1 : OWN2;
      if ((pick == PICK_1 && state_q == OWN1) || (pick == PICK_2 && state_q == OWN2)) begin
        hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? HOLD_MAX : hold_cnt_q + 1'b1;
      end else begin
        hold_cnt_d = HOLD_ONE;
      end
      prio1_d     = (pick == PICK_2);
      last_sel_d  = (pick == PICK_1);
      out1_d      = (pick == PICK_1) ? bus.in1 : bus.in2;
      out_valid_d = 1'b1;
    end else if (can_accept) begin
      if (bus.out_ready) out_valid_d = 1'b0;
      state_d    = IDLE;
      hold_cnt_d = '0;
    end
  end

  // Grants and select; sel falls back to the last routed source when nothing is granted.
  always_comb begin
    gnt1_o = (pick == PICK_1);
    gnt2_o = (pick == PICK_2);
    if (!rst_n)                 sel_o = 1'b1;
    else if (pick != PICK_NONE) sel_o = (pick == PICK_1);
    else                        sel_o = last_sel_q;
  end

  assign bus.gnt1      = gnt1_o;
  assign bus.gnt2      = gnt2_o;
  assign bus.sel       = sel_o;
  assign bus.out_valid = out_valid_q;
  assign bus.out1      = out1_q;

  // At most one requester may be accepted in any cycle.
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(gnt1_o && gnt2_o));

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Controller that shares one WIDTH-bit output path between two requesters, in1 and in2, by generating the mux select.
- Select sense: sel=1 routes in1, sel=0 routes in2.
- Arbitration is round-robin with a bounded hold, so one requester can burst but cannot starve the other.
- Output is a single registered stage with valid/ready toward the consumer.

Parameters:
WIDTH, 3, data width of in1/in2/out1
MAX_HOLD, 4, max consecutive beats granted to one owner while the other requests (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous reset, active-low
req1  input  1  requester 1 has valid data on in1
in1  input  WIDTH  requester 1 data
gnt1  output  1  combinational accept for requester 1 (transfer when req1&&gnt1)
req2  input  1  requester 2 has valid data on in2
in2  input  WIDTH  requester 2 data
gnt2  output  1  combinational accept for requester 2
out_valid  output  1  out1 holds a beat
out_ready  input  1  consumer accepts out1 this cycle
out1  output  WIDTH  registered output beat
sel  output  1  1 = beat from in1, 0 = from in2

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out1=0, state=IDLE, hold_cnt=0, prio=in1, last_sel=1. While rst_n=0, gnt1=gnt2=0 and sel=1.
- can_accept = !out_valid || out_ready. If can_accept=0, gnt1=gnt2=0 and state, hold_cnt, prio and out1 are all frozen.
- Pick logic when can_accept=1:
  - IDLE: both requesting -> pick prio. One requesting -> pick it. None -> no pick.
  - OWN1: req1 && (hold_cnt<MAX_HOLD || !req2) -> pick 1. Else req2 -> pick 2. Else no pick.
  - OWN2: symmetric to OWN1.
- gnt1 = can_accept && pick==1; gnt2 = can_accept && pick==2. At most one grant per cycle.
- sel = pick when a grant is active, otherwise last_sel.
- On a grant edge:
  - out1 <= sel ? in1 : in2; out_valid <= 1; last_sel <= sel.
  - Same owner: hold_cnt <= hold_cnt+1, saturating at MAX_HOLD. Owner change or from IDLE: hold_cnt <= 1.
  - state <= OWN1/OWN2 per pick.
  - prio <= the requester not picked.
- can_accept=1 with no pick:
  - out_valid <= 0 if out_ready.
  - state <= IDLE, hold_cnt <= 0, prio unchanged.
- Latency: a beat granted in cycle N appears on out1 with out_valid=1 in cycle N+1.
- Throughput: 1 beat/cycle with out_ready held high.
- Simultaneous out_ready and grant: old beat leaves and new beat loads in the same edge (no bubble).
- Requester drops req without a grant: no transfer, no state change caused by that requester.
- Owner runs alone: hold limit does not apply and hold_cnt stays saturated; switch happens on the first cycle the other requests at saturation.
- Reset mid-burst: synchronous reset wins over any grant; the in-flight beat is discarded.

Test Plan:
1. rst_n=0 for 3 cycles, req1=req2=1, out_ready=1 -> gnt1=gnt2=0, out_valid=0, out1=3'b000, sel=1 every cycle.
2. After reset, req1=1, in1=3'b101, req2=0, out_ready=1 -> gnt1=1, sel=1 in the same cycle; next cycle out_valid=1, out1=3'b101.
3. req1=req2=1 continuously, in1=3'b001, in2=3'b110, out_ready=1, MAX_HOLD=4 -> grant sequence 1,1,1,1,2,2,2,2,1...; out1 follows one cycle later; never two grants in one cycle.
4. out_valid=1 with out_ready=0 for 5 cycles, both requesting -> gnt1=gnt2=0, out1 stable, hold_cnt frozen; on release, the grant sequence resumes exactly where it paused.
5. OWN1 with hold_cnt=2, req1 drops, req2=1 -> gnt2 next accept cycle, hold_cnt=1, sel=0. Separately: both reqs drop -> IDLE, out_valid=0 after the last beat drains.
6. rst_n=0 for 1 cycle in the middle of an OWN2 burst -> next cycle state=IDLE, out_valid=0; with both requesting, the first grant goes to in1.
